// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the 8-bit CPU sequential control unit.
// Holds FSM state codes, opcode encodings and instruction field widths.
package cpu_ctrl_pkg;

    localparam int OPC_W = 3;

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [OPC_W-1:0] OP_LDA = 3'b000;
    localparam logic [OPC_W-1:0] OP_LDB = 3'b001;
    localparam logic [OPC_W-1:0] OP_STA = 3'b010;
    localparam logic [OPC_W-1:0] OP_ALU = 3'b011;
    localparam logic [OPC_W-1:0] OP_JMP = 3'b100;
    localparam logic [OPC_W-1:0] OP_JZ  = 3'b101;
    localparam logic [OPC_W-1:0] OP_NOP = 3'b110;
    localparam logic [OPC_W-1:0] OP_HLT = 3'b111;

    function automatic logic op_is_mem(input logic [OPC_W-1:0] op);
        return (op == OP_LDA) || (op == OP_LDB) || (op == OP_STA);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags the cycle that reaches the timeout.
// Ports: clk, reset_n, clr_i (zero count), en_i (count a wait cycle), timeout_o.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // The TIMEOUT-th consecutive wait cycle is the one that times out.
    assign timeout_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_control_seq.sv
// Sequential control unit: owns the FSM, decodes IR and drives datapath
// strobes, with memory wait timeout, stall, halt/resume and retire counter.
// Ports: clk, reset_n, instr, zf, mem_ready, stall, resume in;
//        state, PC/addr/mem/ALU/register strobes, halt, fault, retired out.
module cpu_control_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_W     = 8,
    parameter int OFFSET_W    = 4,
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                zf,
    input  logic                mem_ready,
    input  logic                stall,
    input  logic                resume,
    output logic [2:0]          state,
    output logic                pc_we,
    output logic                pc_sel,
    output logic                pc_jmp_sel,
    output logic [OFFSET_W-1:0] pc_offset,
    output logic                addr_sel,
    output logic [OFFSET_W-1:0] addr_offset,
    output logic                mem_sel,
    output logic                mem_we,
    output logic                mem_req,
    output logic [ALU_OP_W-1:0] alu_opcode,
    output logic                alu_sel_a,
    output logic                alu_sel_b,
    output logic                alu_we,
    output logic                zf_we,
    output logic                ir_we,
    output logic                a_sel,
    output logic                a_we,
    output logic                b_sel,
    output logic                b_we,
    output logic                halt,
    output logic                fault,
    output logic [CNT_W-1:0]    retired
);

    logic [2:0]       state_q, state_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             hold;
    logic             waiting;
    logic             tmr_clr;
    logic             timeout;

    logic [OPC_W-1:0]    opc;
    logic [OFFSET_W-1:0] off;
    logic [ALU_OP_W-1:0] aop;
    logic                unused_instr;

    assign opc = instr[INSTR_W-1 -: OPC_W];
    assign off = instr[OFFSET_W-1:0];
    assign aop = instr[ALU_OP_W-1:0];
    assign unused_instr = ^instr;

    // Stall freezes everything except HALT, where only resume matters.
    assign hold = stall && (state_q != S_HALT);
    assign waiting = !hold && !mem_ready &&
                     ((state_q == S_FETCH) || (state_q == S_MEMORY));
    assign tmr_clr = !hold && (mem_ready || (state_d != state_q));

    mem_wait_timer #(
        .TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (tmr_clr),
        .en_i     (waiting),
        .timeout_o(timeout)
    );

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        retire  = 1'b0;
        if (!hold) begin
            unique case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        state_d = S_DECODE;
                    end else if (timeout) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (opc == OP_HLT) begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end else if (opc == OP_NOP) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else if (op_is_mem(opc)) begin
                        state_d = S_MEMORY;
                    end else begin
                        state_d = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    state_d = S_FETCH;
                    if (opc == OP_ALU) begin
                        state_d = S_WRITEBACK;
                    end else if ((opc == OP_JMP) || (opc == OP_JZ)) begin
                        retire = 1'b1;
                    end
                end
                S_MEMORY: begin
                    if (mem_ready) begin
                        state_d = S_FETCH;
                        if (opc == OP_STA) begin
                            retire = 1'b1;
                        end else if ((opc == OP_LDA) || (opc == OP_LDB)) begin
                            state_d = S_WRITEBACK;
                        end
                    end else if (timeout) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
                S_HALT: begin
                    if (resume) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
        retired_d = retired_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign fault   = fault_q;
    assign retired = retired_q;
    assign halt    = reset_n && (state_q == S_HALT);

    always_comb begin
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        pc_jmp_sel  = 1'b0;
        pc_offset   = '0;
        addr_sel    = 1'b0;
        addr_offset = '0;
        mem_sel     = 1'b0;
        mem_we      = 1'b0;
        mem_req     = 1'b0;
        alu_opcode  = '0;
        alu_sel_a   = 1'b0;
        alu_sel_b   = 1'b0;
        alu_we      = 1'b0;
        zf_we       = 1'b0;
        ir_we       = 1'b0;
        a_sel       = 1'b0;
        a_we        = 1'b0;
        b_sel       = 1'b0;
        b_we        = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                S_EXECUTE: begin
                    if (opc == OP_ALU) begin
                        alu_opcode = aop;
                        alu_we     = 1'b1;
                        zf_we      = 1'b1;
                    end else if ((opc == OP_JMP) || (opc == OP_JZ)) begin
                        pc_we     = (opc == OP_JMP) ? 1'b1 : zf;
                        pc_sel    = 1'b1;
                        pc_offset = off;
                    end
                end
                S_MEMORY: begin
                    mem_req     = 1'b1;
                    addr_sel    = 1'b1;
                    addr_offset = off;
                    mem_sel     = 1'b1;
                    mem_we      = (opc == OP_STA);
                end
                S_WRITEBACK: begin
                    if (opc == OP_LDA) begin
                        a_sel = 1'b1;
                        a_we  = 1'b1;
                    end else if (opc == OP_LDB) begin
                        b_sel = 1'b1;
                        b_we  = 1'b1;
                    end else if (opc == OP_ALU) begin
                        a_we = 1'b1;
                    end
                end
                default: ;
            endcase
            // Stalled or abandoned (timed-out) cycles must not commit anything.
            if (hold || timeout) begin
                mem_req = 1'b0;
                mem_we  = 1'b0;
                pc_we   = 1'b0;
                ir_we   = 1'b0;
                alu_we  = 1'b0;
                zf_we   = 1'b0;
                a_we    = 1'b0;
                b_we    = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_control_seq.sv
// Scoreboard bench for cpu_control_seq: per-cycle expectations are queued
// when inputs are driven and compared against the outputs at the falling edge.
module tb_cpu_control_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  instr;
    logic        zf, mem_ready, stall, resume;
    logic [2:0]  state;
    logic        pc_we, pc_sel, pc_jmp_sel;
    logic [3:0]  pc_offset, addr_offset;
    logic        addr_sel, mem_sel, mem_we, mem_req;
    logic [2:0]  alu_opcode;
    logic        alu_sel_a, alu_sel_b, alu_we, zf_we;
    logic        ir_we, a_sel, a_we, b_sel, b_we;
    logic        halt, fault;
    logic [15:0] retired;

    cpu_control_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .instr      (instr),
        .zf         (zf),
        .mem_ready  (mem_ready),
        .stall      (stall),
        .resume     (resume),
        .state      (state),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .pc_jmp_sel (pc_jmp_sel),
        .pc_offset  (pc_offset),
        .addr_sel   (addr_sel),
        .addr_offset(addr_offset),
        .mem_sel    (mem_sel),
        .mem_we     (mem_we),
        .mem_req    (mem_req),
        .alu_opcode (alu_opcode),
        .alu_sel_a  (alu_sel_a),
        .alu_sel_b  (alu_sel_b),
        .alu_we     (alu_we),
        .zf_we      (zf_we),
        .ir_we      (ir_we),
        .a_sel      (a_sel),
        .a_we       (a_we),
        .b_sel      (b_sel),
        .b_we       (b_we),
        .halt       (halt),
        .fault      (fault),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] ASA   = 32'h2_0000;
    localparam logic [31:0] ASB   = 32'h1_0000;
    localparam logic [31:0] PCWE  = 32'h8000;
    localparam logic [31:0] PCSEL = 32'h4000;
    localparam logic [31:0] JSEL  = 32'h2000;
    localparam logic [31:0] ADSEL = 32'h1000;
    localparam logic [31:0] MSEL  = 32'h0800;
    localparam logic [31:0] MWE   = 32'h0400;
    localparam logic [31:0] MREQ  = 32'h0200;
    localparam logic [31:0] ALUWE = 32'h0100;
    localparam logic [31:0] ZFWE  = 32'h0080;
    localparam logic [31:0] IRWE  = 32'h0040;
    localparam logic [31:0] ASRC  = 32'h0020;
    localparam logic [31:0] AWE   = 32'h0010;
    localparam logic [31:0] BSRC  = 32'h0008;
    localparam logic [31:0] BWE   = 32'h0004;
    localparam logic [31:0] HALT  = 32'h0002;
    localparam logic [31:0] FLT   = 32'h0001;

    localparam logic [31:0] FET = MREQ | IRWE | PCWE;
    localparam logic [31:0] MEM = MREQ | ADSEL | MSEL;

    typedef struct packed {
        logic [2:0]  st;
        logic [31:0] fl;
        logic [10:0] dat;
        logic [15:0] ret;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_err = 0;
    string       phase = "init";
    logic        flt = 1'b0;
    logic [15:0] ret = '0;

    logic [31:0] obs_fl;
    logic [10:0] obs_dat;
    assign obs_fl = {14'b0, alu_sel_a, alu_sel_b, pc_we, pc_sel,
                     pc_jmp_sel, addr_sel, mem_sel, mem_we, mem_req,
                     alu_we, zf_we, ir_we, a_sel, a_we, b_sel, b_we,
                     halt, fault};
    assign obs_dat = {alu_opcode, pc_offset, addr_offset};

    function automatic logic [10:0] d_alu(input int v);
        return 11'(v) << 8;
    endfunction
    function automatic logic [10:0] d_pc(input int v);
        return 11'(v) << 4;
    endfunction
    function automatic logic [10:0] d_ad(input int v);
        return 11'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h want %0h", phase, tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("state", 32'(state), 32'(e.st));
            check("flags", obs_fl, e.fl);
            check("fields", 32'(obs_dat), 32'(e.dat));
            check("retired", 32'(retired), 32'(e.ret));
        end
    end

    // One clock cycle: drive inputs, queue what this cycle must show.
    task automatic cyc(input logic [7:0] in, input logic z, input logic r,
                       input logic s, input logic rs, input logic [2:0] est,
                       input logic [31:0] ef, input logic [10:0] ed,
                       input logic rt);
        exp_t x;
        instr     = in;
        zf        = z;
        mem_ready = r;
        stall     = s;
        resume    = rs;
        x.st  = est;
        x.fl  = ef | (flt ? FLT : 32'h0);
        x.dat = ed;
        x.ret = ret;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (rt) ret = ret + 16'd1;
    endtask

    task automatic fd(input logic [7:0] in, input logic z);
        cyc(in, z, 1, 0, 0, 0, FET, 0, 0);
        cyc(in, z, 1, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic do_reset(input logic [7:0] in, input logic z);
        reset_n = 1'b0;
        flt = 1'b0;
        ret = '0;
        cyc(in, z, 1, 0, 1, 0, 0, 0, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        instr = '0;
        zf = 0;
        mem_ready = 0;
        stall = 0;
        resume = 0;
        @(posedge clk);
        #1;

        phase = "reset";
        cyc(8'h63, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(8'hA7, 0, 1, 1, 1, 0, 0, 0, 0);
        reset_n = 1'b1;

        phase = "alu";
        fd(8'h63, 0);
        cyc(8'h63, 0, 1, 0, 0, 2, ALUWE | ZFWE, d_alu(3), 0);
        cyc(8'h63, 0, 1, 0, 0, 4, AWE, 0, 1);

        phase = "lda";
        fd(8'h05, 0);
        for (int i = 0; i < 3; i++)
            cyc(8'h05, 0, 0, 0, 0, 3, MEM, d_ad(5), 0);
        cyc(8'h05, 0, 1, 0, 0, 3, MEM, d_ad(5), 0);
        cyc(8'h05, 0, 1, 0, 0, 4, ASRC | AWE, 0, 1);

        phase = "jz_nt";
        fd(8'hA7, 0);
        cyc(8'hA7, 0, 1, 0, 0, 2, PCSEL, d_pc(7), 1);
        phase = "jz_t";
        fd(8'hA7, 1);
        cyc(8'hA7, 1, 1, 0, 0, 2, PCWE | PCSEL, d_pc(7), 1);
        phase = "jmp";
        fd(8'h83, 0);
        cyc(8'h83, 0, 1, 0, 0, 2, PCWE | PCSEL, d_pc(3), 1);

        phase = "sta";
        fd(8'h4A, 0);
        cyc(8'h4A, 0, 0, 0, 0, 3, MEM | MWE, d_ad(10), 0);
        cyc(8'h4A, 0, 1, 0, 0, 3, MEM | MWE, d_ad(10), 1);

        phase = "nop";
        cyc(8'hC0, 0, 1, 0, 0, 0, FET, 0, 0);
        cyc(8'hC0, 0, 1, 0, 1, 1, 0, 0, 1);

        phase = "hlt";
        cyc(8'hE0, 0, 1, 0, 0, 0, FET, 0, 0);
        cyc(8'hE0, 0, 1, 0, 1, 1, 0, 0, 1);
        cyc(8'hE0, 0, 1, 1, 0, 5, HALT, 0, 0);
        cyc(8'hE0, 0, 1, 0, 0, 5, HALT, 0, 0);
        cyc(8'hE0, 0, 1, 0, 1, 5, HALT, 0, 0);

        phase = "stall";
        cyc(8'h63, 0, 1, 1, 1, 0, 0, 0, 0);
        fd(8'h63, 0);
        cyc(8'h63, 0, 1, 1, 1, 2, 0, d_alu(3), 0);
        cyc(8'h63, 0, 1, 1, 0, 2, 0, d_alu(3), 0);
        cyc(8'h63, 0, 1, 0, 0, 2, ALUWE | ZFWE, d_alu(3), 0);
        cyc(8'h63, 0, 1, 0, 0, 4, AWE, 0, 1);

        phase = "timeout";
        for (int i = 0; i < 7; i++)
            cyc(8'h05, 0, 0, 0, 0, 0, MREQ, 0, 0);
        for (int i = 0; i < 2; i++)
            cyc(8'h05, 0, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++)
            cyc(8'h05, 0, 0, 0, 0, 0, MREQ, 0, 0);
        cyc(8'h05, 0, 0, 0, 0, 0, 0, 0, 0);
        flt = 1'b1;
        cyc(8'h05, 0, 0, 0, 0, 5, HALT, 0, 0);
        cyc(8'h05, 0, 0, 0, 1, 5, HALT, 0, 0);

        phase = "ready_wins";
        fd(8'h23, 0);
        for (int i = 0; i < 14; i++)
            cyc(8'h23, 0, 0, 0, 0, 3, MEM, d_ad(3), 0);
        cyc(8'h23, 0, 1, 0, 0, 3, MEM, d_ad(3), 0);
        cyc(8'h23, 0, 1, 0, 0, 4, BSRC | BWE, 0, 1);

        phase = "rst_halt";
        cyc(8'hE0, 0, 1, 0, 0, 0, FET, 0, 0);
        cyc(8'hE0, 0, 1, 0, 0, 1, 0, 0, 1);
        cyc(8'hE0, 0, 1, 0, 0, 5, HALT, 0, 0);
        do_reset(8'hE0, 1);

        phase = "rst_mem";
        fd(8'h05, 0);
        cyc(8'h05, 0, 0, 0, 0, 3, MEM, d_ad(5), 0);
        do_reset(8'h05, 1);
        fd(8'h05, 0);
        cyc(8'h05, 0, 1, 0, 0, 3, MEM, d_ad(5), 0);
        cyc(8'h05, 0, 1, 0, 0, 4, ASRC | AWE, 0, 1);
        cyc(8'hC0, 0, 0, 0, 0, 0, MREQ, 0, 0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
